// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, RMW for sub-word stores.
// Optional MISALIGN_TRAP_EN traps misaligned halfword/word accesses.
module load_store_unit #(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned,
  output logic            mem_read_enable,
  output logic            mem_write_enable,
  output logic [XLEN-1:0] mem_read_addr,
  output logic [XLEN-1:0] mem_write_addr,
  output logic [3:0][7:0] mem_write_data,
  input  logic [3:0][7:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            store_q, store_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;

  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_mis_q, resp_mis_d;
  logic            mem_re_q, mem_re_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_raddr_q, mem_raddr_d;
  logic [XLEN-1:0] mem_waddr_q, mem_waddr_d;
  logic [3:0][7:0] mem_wdata_q, mem_wdata_d;

  logic [XLEN-1:0] rdata_n;
  logic [3:0][7:0] wword_n;
  logic            mis_n;

  function automatic logic is_legal(
    input logic       st,
    input logic [2:0] f3
  );
    if (st) return f3 inside {3'b000, 3'b001, 3'b010};
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misal(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic half, word;
    half = (f3[1:0] == 2'b01);
    word = (f3[1:0] == 2'b10);
    return (half && a[0]) || (word && (a != 2'b00));
  endfunction
`endif

  function automatic logic [XLEN-1:0] extend(
    input logic [2:0]      f3,
    input logic [3:0][7:0] b
  );
    logic [XLEN-1:0] r;
    r = '0;
    unique case (1'b1)
      (f3 == 3'b000): r = {{(XLEN-8){b[0][7]}}, b[0]};
      (f3 == 3'b001): r = {{(XLEN-16){b[1][7]}}, b[1], b[0]};
      (f3 == 3'b010): r = XLEN'(b);
      (f3 == 3'b100): r = {{(XLEN-8){1'b0}}, b[0]};
      (f3 == 3'b101): r = {{(XLEN-16){1'b0}}, b[1], b[0]};
      default:        r = '0;
    endcase
    return r;
  endfunction

  // Only the low lanes are replaced; the rest come from the read.
  function automatic logic [3:0][7:0] rmw_merge(
    input logic [2:0]      f3,
    input logic [3:0][7:0] rd,
    input logic [15:0]     wd
  );
    logic [3:0][7:0] m;
    m    = rd;
    m[0] = wd[7:0];
    if (f3[0]) m[1] = wd[15:8];
    return m;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_n = '0;
    wword_n = '0;
    mis_n   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          store_d = req_store;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata[15:0];
          if (!is_legal(req_store, req_funct3)) begin
            state_d = RESP;
          end
`ifdef MISALIGN_TRAP_EN
          else if (is_misal(req_funct3, req_addr[1:0])) begin
            state_d = RESP;
            mis_n   = 1'b1;
          end
`endif
          else if (req_store && req_funct3 == 3'b010) begin
            state_d = WRITE;
            wword_n = req_wdata;
          end else begin
            state_d = READ;
            cnt_d   = CNT_INIT;
          end
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          if (store_q) begin
            state_d = WRITE;
            wword_n = rmw_merge(f3_q, mem_read_data, wdata_q);
          end else begin
            state_d = RESP;
            rdata_n = extend(f3_q, mem_read_data);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered: decode from the state being entered.
    req_ready_d  = (state_d == IDLE);
    mem_re_d     = (state_d == READ);
    mem_we_d     = (state_d == WRITE);
    mem_raddr_d  = mem_re_d ? addr_d : '0;
    mem_waddr_d  = mem_we_d ? addr_d : '0;
    mem_wdata_d  = mem_we_d ? wword_n : '0;
    resp_valid_d = (state_d == RESP);
    resp_rdata_d = resp_valid_d ? rdata_n : '0;
    resp_mis_d   = resp_valid_d & mis_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_raddr_q  <= '0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      store_q      <= store_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_raddr_q  <= mem_raddr_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_misaligned  = resp_mis_q;
  assign mem_read_enable  = mem_re_q;
  assign mem_write_enable = mem_we_q;
  assign mem_read_addr    = mem_raddr_q;
  assign mem_write_addr   = mem_waddr_q;
  assign mem_write_data   = mem_wdata_q;

endmodule
